// File: rtl/axi4_slave_mem_if.sv
// rtl/axi4_slave_mem_if.sv - AXI4 full bus bundle with master and slave views
interface axi4_if #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4
);
  logic                          awvalid;
  logic                          awready;
  logic [ADDR_BYTES*8-1:0]       awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic [NUM_ID_BITS_P-1:0]      awid;
  logic [NUM_USER_BITS_P-1:0]    awuser;
  logic [3:0]                    awcache;
  logic [2:0]                    awprot;
  logic                          awlock;
  logic [3:0]                    awregion;
  logic [3:0]                    awqos;

  logic                          wvalid;
  logic                          wready;
  logic [DATA_BYTES*8-1:0]       wdata;
  logic [DATA_BYTES-1:0]         wstrb;
  logic                          wlast;
  logic [NUM_USER_BITS_P-1:0]    wuser;

  logic                          bwvalid;
  logic                          bwready;
  logic [1:0]                    bresp;
  logic [NUM_ID_BITS_P-1:0]      bid;
  logic [NUM_USER_BITS_P-1:0]    buser;

  logic                          arvalid;
  logic                          arready;
  logic [ADDR_BYTES*8-1:0]       araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic [NUM_ID_BITS_P-1:0]      arid;
  logic [NUM_USER_BITS_P-1:0]    aruser;
  logic [3:0]                    arcache;
  logic [2:0]                    arprot;
  logic                          arlock;
  logic [3:0]                    arregion;
  logic [3:0]                    arqos;

  logic                          rvalid;
  logic                          rready;
  logic [DATA_BYTES*8-1:0]       rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic [NUM_ID_BITS_P-1:0]      rid;
  logic [NUM_USER_BITS_P-1:0]    ruser;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid, awuser,
           awcache, awprot, awlock, awregion, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wuser,
    input  wready,
    input  bwvalid, bresp, bid, buser,
    output bwready,
    output arvalid, araddr, arlen, arsize, arburst, arid, aruser,
           arcache, arprot, arlock, arregion, arqos,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid, ruser,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid, awuser,
           awcache, awprot, awlock, awregion, awqos,
    output awready,
    input  wvalid, wdata, wstrb, wlast, wuser,
    output wready,
    output bwvalid, bresp, bid, buser,
    input  bwready,
    input  arvalid, araddr, arlen, arsize, arburst, arid, aruser,
           arcache, arprot, arlock, arregion, arqos,
    output arready,
    output rvalid, rdata, rresp, rlast, rid, ruser,
    input  rready
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 full slave backed by a byte-addressable register memory
// Independent write and read FSMs, one outstanding transaction each; FIXED/INCR/WRAP bursts.
module axi4_slave_mem #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4
) (
  input logic   aclk,
  input logic   areset,
  axi4_if.slave bus
);

  localparam int ADDR_W    = ADDR_BYTES * 8;
  localparam int DATA_W    = DATA_BYTES * 8;
  localparam int LOG2_DB   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 0;
  localparam int IDX_W     = ADDR_W - LOG2_DB;
  localparam int NUM_WORDS = 1 << IDX_W;
  // wide enough for a 16-beat wrap window of 128-byte beats
  localparam int EXT_W     = ADDR_W + 16;
  localparam logic [2:0] MAX_SIZE    = 3'(LOG2_DB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic cmd_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (size > MAX_SIZE) || (burst == 2'd3) ||
           ((burst == 2'd2) && !wrap_len_ok(len));
  endfunction

  // Illegal WRAP lengths and the reserved burst type both advance like INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [EXT_W-1:0] a_x;
    logic [EXT_W-1:0] step;
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] res;
    a_x  = EXT_W'(addr);
    step = EXT_W'(1) << size;
    mask = ((EXT_W'(len) + EXT_W'(1)) << size) - EXT_W'(1);
    sum  = a_x + step;
    res  = sum;
    if (burst == 2'd0) begin
      res = a_x;
    end else if ((burst == 2'd2) && wrap_len_ok(len)) begin
      res = (a_x & ~mask) | (sum & mask);
    end
    return ADDR_W'(res);
  endfunction

  logic [DATA_W-1:0] mem [NUM_WORDS];

  // ---------------- write path ----------------
  w_state_t                   w_state, w_next;
  logic                       awready_q, wready_q, bvalid_q;
  logic [ADDR_W-1:0]          w_addr;
  logic [7:0]                 w_len, w_cnt;
  logic [2:0]                 w_size;
  logic [1:0]                 w_burst;
  logic [NUM_ID_BITS_P-1:0]   w_id;
  logic                       w_err, w_size_err;
  logic                       aw_hs, w_hs, b_hs, w_last_beat;
  logic [IDX_W-1:0]           w_idx;

  assign aw_hs       = bus.awvalid & awready_q;
  assign w_hs        = bus.wvalid & wready_q;
  assign b_hs        = bvalid_q & bus.bwready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_idx       = w_addr[ADDR_W-1:LOG2_DB];

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Ready/valid flags are registered from the next state so they stay low through reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      bvalid_q  <= (w_next == W_RESP);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_addr     <= '0;
      w_len      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_id       <= '0;
      w_cnt      <= '0;
      w_err      <= 1'b0;
      w_size_err <= 1'b0;
    end else if (aw_hs) begin
      w_addr     <= bus.awaddr;
      w_len      <= bus.awlen;
      w_size     <= bus.awsize;
      w_burst    <= bus.awburst;
      w_id       <= bus.awid;
      w_cnt      <= '0;
      w_err      <= cmd_err(bus.awlen, bus.awsize, bus.awburst);
      w_size_err <= (bus.awsize > MAX_SIZE);
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      if (bus.wlast != w_last_beat) w_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (w_hs && !w_size_err) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (bus.wstrb[b]) mem[w_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t                   r_state, r_next;
  logic                       arready_q, rvalid_q;
  logic [ADDR_W-1:0]          r_addr;
  logic [7:0]                 r_len, r_cnt;
  logic [2:0]                 r_size;
  logic [1:0]                 r_burst;
  logic [NUM_ID_BITS_P-1:0]   r_id;
  logic                       r_err, r_size_err;
  logic                       ar_hs, r_hs, r_last_beat;
  logic [IDX_W-1:0]           r_idx;

  assign ar_hs       = bus.arvalid & arready_q;
  assign r_hs        = rvalid_q & bus.rready;
  assign r_last_beat = (r_cnt == r_len);
  assign r_idx       = r_addr[ADDR_W-1:LOG2_DB];

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_id       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_size_err <= 1'b0;
    end else if (ar_hs) begin
      r_addr     <= bus.araddr;
      r_len      <= bus.arlen;
      r_size     <= bus.arsize;
      r_burst    <= bus.arburst;
      r_id       <= bus.arid;
      r_cnt      <= '0;
      r_err      <= cmd_err(bus.arlen, bus.arsize, bus.arburst);
      r_size_err <= (bus.arsize > MAX_SIZE);
    end else if (r_hs) begin
      r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // ---------------- outputs ----------------
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bwvalid = bvalid_q;
  assign bus.bresp   = (bvalid_q && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign bus.bid     = w_id;
  assign bus.buser   = '0;

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  // Read is combinational from the array, so a same-cycle write is seen one cycle later.
  assign bus.rdata   = (rvalid_q && !r_size_err) ? mem[r_idx] : '0;
  assign bus.rresp   = (rvalid_q && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign bus.rlast   = rvalid_q & r_last_beat;
  assign bus.rid     = r_id;
  assign bus.ruser   = '0;

  logic unused_ok;
  assign unused_ok = ^{bus.awuser, bus.awcache, bus.awprot, bus.awlock, bus.awregion,
                       bus.awqos, bus.wuser, bus.aruser, bus.arcache, bus.arprot,
                       bus.arlock, bus.arregion, bus.arqos};

endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb/tb_axi4_slave_mem.sv - directed table-driven bench for axi4_slave_mem
module tb_axi4_slave_mem;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_if #(.DATA_BYTES(4), .ADDR_BYTES(1), .NUM_ID_BITS_P(4), .NUM_USER_BITS_P(4)) bus ();

  axi4_slave_mem #(.DATA_BYTES(4), .ADDR_BYTES(1), .NUM_ID_BITS_P(4), .NUM_USER_BITS_P(4)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  task automatic send_aw(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) timeout("aw");
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) timeout("w");
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    bus.bwready = 1'b1;
    while (bus.bwvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) timeout("b");
    resp = bus.bresp; id = bus.bid;
    @(posedge aclk); #1;
    bus.bwready = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) timeout("ar");
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic get_r(output logic [31:0] d, output logic [1:0] resp, output logic last,
                       output logic [3:0] id);
    int n = 0;
    bus.rready = 1'b1;
    while (bus.rvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) timeout("r");
    d = bus.rdata; resp = bus.rresp; last = bus.rlast; id = bus.rid;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(bus.awready), 32'd0);
    chk({tag, "_arready"}, 32'(bus.arready), 32'd0);
    chk({tag, "_wready"},  32'(bus.wready),  32'd0);
    chk({tag, "_bwvalid"}, 32'(bus.bwvalid), 32'd0);
    chk({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
    chk({tag, "_outs"}, {bus.rdata[15:0], 2'b0, bus.bresp, bus.rresp, bus.rlast, 1'b0,
                         bus.bid, bus.rid}, 32'd0);
  endtask

  logic [1:0]  resp;
  logic [3:0]  id;
  logic [31:0] d;
  logic        last;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h40, 3'd2, 2'd1, 32'hFFFFFFFF, 4'hF, 2'd0, 32'hFFFFFFFF};
    vecs[1] = '{8'h40, 3'd2, 2'd1, 32'h0000AAAA, 4'h3, 2'd0, 32'hFFFFAAAA};
    vecs[2] = '{8'h50, 3'd3, 2'd1, 32'h12345678, 4'hF, 2'd2, 32'h00000000};
    vecs[3] = '{8'h60, 3'd0, 2'd1, 32'h000000CD, 4'h1, 2'd0, 32'h000000CD};
    vecs[4] = '{8'h61, 3'd0, 2'd1, 32'h0000EF00, 4'h2, 2'd0, 32'h0000EFCD};
    vecs[5] = '{8'h64, 3'd2, 2'd3, 32'h11111111, 4'hF, 2'd2, 32'h11111111};
    vecs[6] = '{8'h68, 3'd2, 2'd2, 32'h22222222, 4'hF, 2'd2, 32'h22222222};
    vecs[7] = '{8'hFC, 3'd2, 2'd1, 32'hCAFEF00D, 4'hF, 2'd0, 32'hCAFEF00D};
    vecs[8] = '{8'h6C, 3'd1, 2'd0, 32'h0000BEEF, 4'h3, 2'd0, 32'h0000BEEF};

    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.awid = 0; bus.awuser = 0; bus.awcache = 0; bus.awprot = 0; bus.awlock = 0;
    bus.awregion = 0; bus.awqos = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wuser = 0;
    bus.bwready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.arid = 0; bus.aruser = 0; bus.arcache = 0; bus.arprot = 0; bus.arlock = 0;
    bus.arregion = 0; bus.arqos = 0;
    bus.rready = 0;

    // reset state and release timing
    repeat (3) @(posedge aclk);
    #1;
    chk_all_zero("rst");
    areset = 1'b0;
    #1;
    chk("rel_awready_low", 32'(bus.awready), 32'd0);
    @(posedge aclk); #1;
    chk("rel_awready", 32'(bus.awready), 32'd1);
    chk("rel_arready", 32'(bus.arready), 32'd1);

    // single write / read with handshake timing
    send_aw(8'h10, 8'd0, 3'd2, 2'd1, 4'd5);
    chk("aw_awready_drop", 32'(bus.awready), 32'd0);
    chk("aw_wready_rise", 32'(bus.wready), 32'd1);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    chk("w_wready_drop", 32'(bus.wready), 32'd0);
    chk("w_bwvalid_rise", 32'(bus.bwvalid), 32'd1);
    get_b(resp, id);
    chk("single_bresp", 32'(resp), 32'd0);
    chk("single_bid", 32'(id), 32'd5);
    chk("b_awready_back", 32'(bus.awready), 32'd1);
    send_ar(8'h10, 8'd0, 3'd2, 2'd1, 4'd3);
    chk("ar_rvalid_rise", 32'(bus.rvalid), 32'd1);
    get_r(d, resp, last, id);
    chk("single_rdata", d, 32'hDEADBEEF);
    chk("single_rresp", 32'(resp), 32'd0);
    chk("single_rid", 32'(id), 32'd3);
    chk("single_rlast", 32'(last), 32'd1);
    chk("r_rvalid_drop", 32'(bus.rvalid), 32'd0);
    chk("r_arready_back", 32'(bus.arready), 32'd1);

    // single-beat vector table
    for (int i = 0; i < 9; i++) begin
      send_aw(vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, 4'd1);
      send_w(vecs[i].data, vecs[i].strb, 1'b1);
      get_b(resp, id);
      chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_bresp));
      send_ar(vecs[i].addr, 8'd0, 3'd2, 2'd1, 4'd2);
      get_r(d, resp, last, id);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'd0);
    end

    // INCR burst, read back with rready toggling
    send_aw(8'h20, 8'd3, 3'd2, 2'd1, 4'd4);
    for (int k = 0; k < 4; k++) send_w(32'(k + 1), 4'hF, k == 3);
    get_b(resp, id);
    chk("incr_bresp", 32'(resp), 32'd0);
    send_ar(8'h20, 8'd3, 3'd2, 2'd1, 4'd4);
    begin
      int beats = 0;
      int cyc = 0;
      logic [31:0] held = '0;
      logic stall = 1'b0;
      while (beats < 4 && cyc < 40) begin
        bus.rready = (cyc % 2 == 0);
        if (bus.rvalid) begin
          if (stall) chk("incr_hold", bus.rdata, held);
          if (bus.rready) begin
            chk($sformatf("incr_beat%0d", beats), bus.rdata, 32'(beats + 1));
            chk($sformatf("incr_rlast%0d", beats), 32'(bus.rlast), (beats == 3) ? 32'd1 : 32'd0);
            beats++;
            stall = 1'b0;
          end else begin
            held = bus.rdata;
            stall = 1'b1;
          end
        end
        @(posedge aclk); #1;
        cyc++;
      end
      bus.rready = 1'b0;
      if (beats < 4) timeout("incr_read");
    end

    // WRAP write at 0x38 lands at 38,3C,30,34
    send_aw(8'h38, 8'd3, 3'd2, 2'd2, 4'd6);
    send_w(32'hA, 4'hF, 1'b0);
    send_w(32'hB, 4'hF, 1'b0);
    send_w(32'hC, 4'hF, 1'b0);
    send_w(32'hD, 4'hF, 1'b1);
    get_b(resp, id);
    chk("wrap_bresp", 32'(resp), 32'd0);
    send_ar(8'h30, 8'd3, 3'd2, 2'd1, 4'd6);
    get_r(d, resp, last, id); chk("wrap_r0", d, 32'hC);
    get_r(d, resp, last, id); chk("wrap_r1", d, 32'hD);
    get_r(d, resp, last, id); chk("wrap_r2", d, 32'hA);
    get_r(d, resp, last, id); chk("wrap_r3", d, 32'hB);
    chk("wrap_rlast", 32'(last), 32'd1);

    // early wlast: all four beats still consumed and written
    send_aw(8'h80, 8'd3, 3'd2, 2'd1, 4'd9);
    for (int k = 0; k < 3; k++) send_w(32'h100 + 32'(k), 4'hF, k == 1);
    chk("wlast_wready_still", 32'(bus.wready), 32'd1);
    chk("wlast_no_bvalid", 32'(bus.bwvalid), 32'd0);
    send_w(32'h103, 4'hF, 1'b0);
    get_b(resp, id);
    chk("wlast_bresp", 32'(resp), 32'd2);
    chk("wlast_bid", 32'(id), 32'd9);
    send_ar(8'h8C, 8'd0, 3'd2, 2'd1, 4'd0);
    get_r(d, resp, last, id);
    chk("wlast_beat3_data", d, 32'h103);

    // reserved read burst: SLVERR on every beat, INCR wraps past top of memory
    send_ar(8'hFC, 8'd1, 3'd2, 2'd3, 4'd7);
    get_r(d, resp, last, id);
    chk("rsv_d0", d, 32'hCAFEF00D);
    chk("rsv_resp0", 32'(resp), 32'd2);
    chk("rsv_last0", 32'(last), 32'd0);
    get_r(d, resp, last, id);
    chk("rsv_d1", d, 32'd0);
    chk("rsv_resp1", 32'(resp), 32'd2);
    chk("rsv_last1", 32'(last), 32'd1);

    // reset in the middle of a len=7 write
    send_aw(8'hA0, 8'd7, 3'd2, 2'd1, 4'd7);
    send_w(32'h55, 4'hF, 1'b0);
    send_w(32'h66, 4'hF, 1'b0);
    areset = 1'b1;
    bus.wvalid = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    chk("midrst_awready_low", 32'(bus.awready), 32'd0);
    @(posedge aclk); #1;
    chk("midrst_awready", 32'(bus.awready), 32'd1);
    chk("midrst_arready", 32'(bus.arready), 32'd1);
    chk("midrst_no_bvalid", 32'(bus.bwvalid), 32'd0);
    send_ar(8'hA0, 8'd1, 3'd2, 2'd1, 4'd1);
    get_r(d, resp, last, id); chk("midrst_r0", d, 32'd0);
    get_r(d, resp, last, id); chk("midrst_r1", d, 32'd0);
    send_ar(8'h10, 8'd0, 3'd2, 2'd1, 4'd1);
    get_r(d, resp, last, id); chk("midrst_cleared", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
